bitmap_release: RTL and testbench
=================================

// Module: bitmap_release
// PURPOSE
//  Owner of the 64-entry block-allocation bitmap (1 = used, 0 = free).
//  Release side of the allocator: accepts free requests (start pos + run length), checks the
//  range, clears the bits, and reports OK / range error / double-free.
//  Also merges the set-mask committed by the first-zero search (alloc path), so
//  bitmap_out is the single source of truth fed back to that search.
// PARAMETERS
//  WIDTH      64   bitmap entries
//  POS_W      7    position/length/count width (holds 0..WIDTH)
//  RESET_MAP  0    bitmap value loaded on reset (all free)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  alloc_valid  in   1        commit alloc_mask this cycle
//  alloc_mask   in   WIDTH    bits to set (one-hot from first-zero search)
//  free_valid   in   1        free request valid
//  free_ready   out  1        free request accepted when valid&&ready
//  free_pos     in   POS_W    first bit of run to free
//  free_len     in   POS_W    run length, 1..WIDTH
//  resp_valid   out  1        one-cycle response pulse
//  resp_err     out  2        00 OK, 01 RANGE, 10 DOUBLE_FREE (valid with resp_valid)
//  alloc_conflict out 1       pulse: alloc_mask hit an already-set bit
//  bitmap_out   out  WIDTH    current bitmap (registered)
//  free_count   out  POS_W    number of 0 bits in bitmap_out (registered)
// BEHAVIOUR
//  Reset (async): state=IDLE, bitmap_out=RESET_MAP, free_count=zeros(RESET_MAP),
//   free_ready=1, resp_valid=0, resp_err=00, alloc_conflict=0. Reset mid-request discards it, no resp.
//  FSM IDLE -> CHECK -> COMMIT -> IDLE. free_ready=1 only in IDLE; pos/len latched on accept.
//  CHECK (1 cycle): clr_mask = ((1<<len)-1)<<pos computed in WIDTH+1 bits, truncated.
//   RANGE if len==0 or pos>=WIDTH or pos+len>WIDTH (POS_W+1-bit sum; len=WIDTH at pos=0 legal).
//   Else DOUBLE_FREE if (bitmap_out & clr_mask) != clr_mask. RANGE has priority. err registered.
//  COMMIT (1 cycle): resp_valid=1, resp_err=registered err. If OK, bitmap cleared at end of cycle.
//  Latency: accept edge k -> resp_valid high in cycle k+2 -> bitmap_out/new request from k+3;
//   free_count updates one cycle after bitmap_out (k+4). No back-pressure on resp.
//  Alloc path: any state; bitmap_next = (bitmap & ~clr_en) | (alloc_valid ? alloc_mask : 0),
//   clr_en = clr_mask only in COMMIT with OK. Set applied in the same edge as a clear; overlap
//   of alloc_mask and clr_en: set wins. alloc_conflict pulses next cycle if alloc_mask & bitmap_out != 0.
//  Check uses bitmap_out sampled in CHECK; alloc during CHECK/COMMIT only sets bits, so an OK
//   check stays valid. free_valid held while not ready: no effect until IDLE.
// TESTING
//  Reset -> bitmap_out=0, free_count=64, free_ready=1, resp_valid=0.
//  alloc_mask=0xFF; free pos=2 len=3 -> resp k+2 err=00, bitmap 0xE3, free_count=59.
//  free pos=2 len=1 again -> err=10, bitmap stays 0xE3; pos=60 len=5 and len=0 -> err=01.
//  alloc all ones; free pos=0 len=64 -> err=00, bitmap 0, free_count 64.
//  alloc_mask bit40 during COMMIT of pos=0 len=8 -> bitmap has bit40 set, bits 0..7 clear.
//  rst_n low during CHECK -> no resp_valid, bitmap=RESET_MAP; alloc on set bit -> alloc_conflict=1.

Source files
------------

// File: rtl/bitmap_release_if.sv
// Request/response and bitmap bus between the allocator front end and bitmap_release.
interface bitmap_release_if #(
  parameter int WIDTH = 64,
  parameter int POS_W = 7
);
  logic             alloc_valid;
  logic [WIDTH-1:0] alloc_mask;
  logic             free_valid;
  logic             free_ready;
  logic [POS_W-1:0] free_pos;
  logic [POS_W-1:0] free_len;
  logic             resp_valid;
  logic [1:0]       resp_err;
  logic             alloc_conflict;
  logic [WIDTH-1:0] bitmap_out;
  logic [POS_W-1:0] free_count;

  modport master (
    output alloc_valid, alloc_mask, free_valid, free_pos, free_len,
    input  free_ready, resp_valid, resp_err, alloc_conflict, bitmap_out, free_count
  );

  modport slave (
    input  alloc_valid, alloc_mask, free_valid, free_pos, free_len,
    output free_ready, resp_valid, resp_err, alloc_conflict, bitmap_out, free_count
  );
endinterface

// File: rtl/bitmap_release.sv
// Block-allocation bitmap owner: range/double-free checked run release plus alloc set-mask merge.
module bitmap_release #(
  parameter int               WIDTH     = 64,
  parameter int               POS_W     = 7,
  parameter logic [WIDTH-1:0] RESET_MAP = {WIDTH{1'b0}}
) (
  input logic            clk,
  input logic            rst_n,
  bitmap_release_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0]     ERR_OK    = 2'b00;
  localparam logic [1:0]     ERR_RANGE = 2'b01;
  localparam logic [1:0]     ERR_DFREE = 2'b10;
  localparam logic [POS_W:0] LIMIT     = (POS_W+1)'(WIDTH);

  function automatic logic [POS_W-1:0] zero_count(input logic [WIDTH-1:0] map);
    logic [POS_W-1:0] cnt;
    cnt = {POS_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(POS_W-1){1'b0}}, ~map[i]};
    end
    return cnt;
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] r_len;
  logic [WIDTH:0]   w_mask_wide;
  logic [WIDTH-1:0] w_clr_mask;
  logic [WIDTH-1:0] w_clr_en;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_bitmap_next;
  logic [POS_W:0]   w_sum;
  logic [1:0]       w_err;
  logic             r_free_ready;
  logic             r_resp_valid;
  logic [1:0]       r_resp_err;
  logic             r_alloc_conflict;
  logic [WIDTH-1:0] r_bitmap;
  logic [POS_W-1:0] r_free_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and accept decode
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.free_valid) begin
          w_state_next = S_CHECK;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CHECK:  w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Run mask is built one bit wider so len == WIDTH does not overflow the shift
  always_comb begin
    w_mask_wide = (({{WIDTH{1'b0}}, 1'b1} << r_len) - {{WIDTH{1'b0}}, 1'b1}) << r_pos;
    w_clr_mask  = w_mask_wide[WIDTH-1:0];
    w_sum       = {1'b0, r_pos} + {1'b0, r_len};
    if ((r_len == {POS_W{1'b0}}) || ({1'b0, r_pos} >= LIMIT) || (w_sum > LIMIT)) begin
      w_err = ERR_RANGE;
    end else if ((r_bitmap & w_clr_mask) != w_clr_mask) begin
      w_err = ERR_DFREE;
    end else begin
      w_err = ERR_OK;
    end
  end

  // Set wins over clear when the same bit is committed and released together
  always_comb begin
    if ((r_state == S_COMMIT) && (r_resp_err == ERR_OK)) begin
      w_clr_en = w_clr_mask;
    end else begin
      w_clr_en = {WIDTH{1'b0}};
    end
    if (bus.alloc_valid) begin
      w_set = bus.alloc_mask;
    end else begin
      w_set = {WIDTH{1'b0}};
    end
    w_bitmap_next = (r_bitmap & ~w_clr_en) | w_set;
  end

  // Request latch on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= {POS_W{1'b0}};
      r_len <= {POS_W{1'b0}};
    end else if (w_accept) begin
      r_pos <= bus.free_pos;
      r_len <= bus.free_len;
    end else begin
      r_pos <= r_pos;
      r_len <= r_len;
    end
  end

  // Handshake and response outputs; resp_err doubles as the commit qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_ready <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= ERR_OK;
    end else begin
      r_free_ready <= (w_state_next == S_IDLE);
      r_resp_valid <= (r_state == S_CHECK);
      if (r_state == S_CHECK) begin
        r_resp_err <= w_err;
      end else begin
        r_resp_err <= r_resp_err;
      end
    end
  end

  // Bitmap, conflict flag and free counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap         <= RESET_MAP;
      r_alloc_conflict <= 1'b0;
      r_free_count     <= zero_count(RESET_MAP);
    end else begin
      r_bitmap         <= w_bitmap_next;
      r_alloc_conflict <= bus.alloc_valid && (|(bus.alloc_mask & r_bitmap));
      r_free_count     <= zero_count(r_bitmap);
    end
  end

  assign bus.free_ready     = r_free_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_err       = r_resp_err;
  assign bus.alloc_conflict = r_alloc_conflict;
  assign bus.bitmap_out     = r_bitmap;
  assign bus.free_count     = r_free_count;

endmodule

// File: tb/tb_bitmap_release.sv
// Directed scoreboard bench for bitmap_release.
module tb_bitmap_release;

  localparam int WIDTH = 64;
  localparam int POS_W = 7;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] exp_map;
  logic [1:0]       sb_q[$];

  bitmap_release_if #(.WIDTH(WIDTH), .POS_W(POS_W)) bus ();

  bitmap_release #(.WIDTH(WIDTH), .POS_W(POS_W), .RESET_MAP({WIDTH{1'b0}})) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input logic [WIDTH-1:0] mask);
    logic exp_conf;
    exp_conf = |(mask & exp_map);
    exp_map  = exp_map | mask;
    bus.alloc_valid = 1'b1;
    bus.alloc_mask  = mask;
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    bus.alloc_mask  = {WIDTH{1'b0}};
    check("alloc_bitmap", bus.bitmap_out, exp_map);
    check("alloc_conflict", {63'd0, bus.alloc_conflict}, {63'd0, exp_conf});
    @(negedge clk);
    check("alloc_free_count", {57'd0, bus.free_count}, 64'(WIDTH - $countones(exp_map)));
  endtask

  // Issue one free; exp_err is the planned outcome, cmask is an alloc driven during COMMIT
  task automatic do_free(input int pos, input int len, input logic [1:0] exp_err,
                         input logic [WIDTH-1:0] cmask);
    int lat;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] clr;
    logic [1:0]       got;
    logic             exp_conf;
    lat = 0;
    while (!bus.free_ready && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("ready_wait", {63'd0, bus.free_ready}, 64'd1);
    bus.free_valid = 1'b1;
    bus.free_pos   = POS_W'(pos);
    bus.free_len   = POS_W'(len);
    sb_q.push_back(exp_err);
    @(negedge clk);
    bus.free_valid = 1'b0;
    check("ready_busy", {63'd0, bus.free_ready}, 64'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check("resp_latency", 64'(lat), 64'd2);
    exp_conf = 1'b0;
    if (bus.resp_valid) begin
      if (sb_q.size() > 0) begin
        got = sb_q.pop_front();
        check("resp_err", {62'd0, bus.resp_err}, {62'd0, got});
      end else begin
        check("sb_underflow", 64'd1, 64'd0);
      end
      if (cmask != {WIDTH{1'b0}}) begin
        exp_conf        = |(cmask & exp_map);
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = cmask;
      end
    end
    wide = ((65'd1 << len) - 65'd1) << pos;
    clr  = wide[WIDTH-1:0];
    if (exp_err == 2'b00) exp_map = exp_map & ~clr;
    exp_map = exp_map | cmask;
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    bus.alloc_mask  = {WIDTH{1'b0}};
    check("free_bitmap", bus.bitmap_out, exp_map);
    check("resp_pulse_end", {63'd0, bus.resp_valid}, 64'd0);
    if (cmask != {WIDTH{1'b0}}) check("commit_conflict", {63'd0, bus.alloc_conflict}, {63'd0, exp_conf});
    @(negedge clk);
    check("free_count", {57'd0, bus.free_count}, 64'(WIDTH - $countones(exp_map)));
  endtask

  initial begin
    logic seen;
    checks = 0;
    errors = 0;
    exp_map = {WIDTH{1'b0}};
    rst_n = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_mask  = {WIDTH{1'b0}};
    bus.free_valid  = 1'b0;
    bus.free_pos    = {POS_W{1'b0}};
    bus.free_len    = {POS_W{1'b0}};
    repeat (2) @(negedge clk);
    check("rst_bitmap", bus.bitmap_out, 64'd0);
    check("rst_free_count", {57'd0, bus.free_count}, 64'd64);
    check("rst_ready", {63'd0, bus.free_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_conflict", {63'd0, bus.alloc_conflict}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_alloc(64'hFF);
    do_free(2, 3, 2'b00, 64'd0);
    check("map_E3", bus.bitmap_out, 64'hE3);
    do_free(2, 1, 2'b10, 64'd0);
    do_free(60, 5, 2'b01, 64'd0);
    do_free(0, 0, 2'b01, 64'd0);
    do_free(64, 1, 2'b01, 64'd0);
    do_free(63, 1, 2'b10, 64'd0);
    check("map_still_E3", bus.bitmap_out, 64'hE3);

    do_alloc({WIDTH{1'b1}});
    do_free(0, 64, 2'b00, 64'd0);
    check("map_all_free", bus.bitmap_out, 64'd0);

    do_alloc(64'hFF);
    do_free(0, 8, 2'b00, (64'd1 << 40) | 64'h8);
    check("map_set_wins", bus.bitmap_out, 64'h0000_0100_0000_0008);

    // Reset while the request sits in CHECK: request discarded, no response
    bus.free_valid = 1'b1;
    bus.free_pos   = POS_W'(3);
    bus.free_len   = POS_W'(1);
    @(negedge clk);
    bus.free_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_map = {WIDTH{1'b0}};
    check("midrst_bitmap", bus.bitmap_out, 64'd0);
    check("midrst_resp", {63'd0, bus.resp_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", {63'd0, seen}, 64'd0);
    check("midrst_free_count", {57'd0, bus.free_count}, 64'd64);
    do_alloc(64'h20);
    do_alloc(64'h20);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
